// File: rtl/inference_pkg.sv
// -----------------------------------------------------------------------------
// inference_pkg
// Shared definitions for the inference datapath: output-layer geometry
// (number of logits, logit width, class index width) and the state
// encoding of the argmax classifier that post-processes the output logits.
// -----------------------------------------------------------------------------
package inference_pkg;

    localparam int OUTPUT_SIZE  = 10;
    localparam int OUTPUT_WIDTH = 32;
    localparam int CLASS_BITS   = $clog2(OUTPUT_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } argmax_state_t;

endpackage : inference_pkg

// File: rtl/argmax_classifier.sv
// -----------------------------------------------------------------------------
// argmax_classifier
// Reads OUTPUT_SIZE signed logits from the outputs RAM after inference
// completes, finds the index of the largest (lowest index wins on ties) and
// presents index and score on a valid/ready result port.
//
// Ports:
//   clk                   single clock, rising edge
//   rst_n                 asynchronous active-low reset
//   start                 one-cycle pulse from inference Done (IDLE only)
//   busy                  high from the cycle after an accepted start until
//                         the result handshake completes
//   outputs_read_en       outputs RAM read enable
//   outputs_read_address  outputs RAM read address
//   outputs_read_data     RAM data, valid one cycle after read enable
//   class_valid           result valid
//   class_ready           consumer accepts the result
//   class_id              index of the maximum logit
//   class_score           value of the maximum logit (raw)
// -----------------------------------------------------------------------------
module argmax_classifier #(
    parameter int OUTPUT_SIZE       = inference_pkg::OUTPUT_SIZE,
    parameter int OUTPUT_WIDTH      = inference_pkg::OUTPUT_WIDTH,
    parameter int OUTPUT_DEPTH_BITS = $clog2(OUTPUT_SIZE),
    parameter int CLASS_BITS        = $clog2(OUTPUT_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         outputs_read_en,
    output logic [OUTPUT_DEPTH_BITS-1:0] outputs_read_address,
    input  logic [OUTPUT_WIDTH-1:0]      outputs_read_data,
    output logic                         class_valid,
    input  logic                         class_ready,
    output logic [CLASS_BITS-1:0]        class_id,
    output logic [OUTPUT_WIDTH-1:0]      class_score
);

    import inference_pkg::*;

    localparam logic [OUTPUT_DEPTH_BITS-1:0] LAST_ADDR = OUTPUT_DEPTH_BITS'(OUTPUT_SIZE - 1);
    localparam logic [OUTPUT_DEPTH_BITS-1:0] ADDR_ONE  = OUTPUT_DEPTH_BITS'(1);

    argmax_state_t                  state_r;
    argmax_state_t                  state_next_s;

    logic                           last_addr_s;
    logic                           busy_next_s;
    logic                           read_en_next_s;
    logic [OUTPUT_DEPTH_BITS-1:0]   addr_next_s;
    logic                           valid_next_s;
    logic                           load_result_s;

    // Compare pipeline: rd_valid_r/rd_idx_r are the read enable and address
    // delayed by the RAM latency, so they line up with outputs_read_data.
    logic                           rd_valid_r;
    logic [CLASS_BITS-1:0]          rd_idx_r;
    logic signed [OUTPUT_WIDTH-1:0] max_score_r;
    logic [CLASS_BITS-1:0]          max_id_r;
    logic                           take_s;
    logic signed [OUTPUT_WIDTH-1:0] max_score_next_s;
    logic [CLASS_BITS-1:0]          max_id_next_s;

    assign last_addr_s = (outputs_read_address == LAST_ADDR);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (last_addr_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                state_next_s = ST_HOLD;
            end
            ST_HOLD: begin
                // class_valid is high throughout HOLD, so ready alone completes it
                if (class_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: next values of the registered outputs
    always_comb begin
        busy_next_s    = (state_next_s != ST_IDLE);
        read_en_next_s = (state_next_s == ST_READ);
        valid_next_s   = (state_next_s == ST_HOLD);
        // the final datum is compared during DRAIN, so the result is taken then
        load_result_s  = (state_r == ST_DRAIN);
        addr_next_s    = outputs_read_address;
        if ((state_r == ST_IDLE) && start) begin
            addr_next_s = '0;
        end else if ((state_r == ST_READ) && !last_addr_s) begin
            addr_next_s = outputs_read_address + ADDR_ONE;
        end else begin
            addr_next_s = outputs_read_address;
        end
    end

    // Running-max update: address 0 loads unconditionally, later data only
    // when strictly greater, which keeps the lowest index on ties
    always_comb begin
        take_s           = 1'b0;
        max_score_next_s = max_score_r;
        max_id_next_s    = max_id_r;
        if (rd_valid_r) begin
            take_s = (rd_idx_r == '0) ||
                     ($signed(outputs_read_data) > max_score_r);
        end else begin
            take_s = 1'b0;
        end
        if (take_s) begin
            max_score_next_s = $signed(outputs_read_data);
            max_id_next_s    = rd_idx_r;
        end else begin
            max_score_next_s = max_score_r;
            max_id_next_s    = max_id_r;
        end
    end

    // Registered control outputs and read address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy                 <= 1'b0;
            outputs_read_en      <= 1'b0;
            outputs_read_address <= '0;
            class_valid          <= 1'b0;
        end else begin
            busy                 <= busy_next_s;
            outputs_read_en      <= read_en_next_s;
            outputs_read_address <= addr_next_s;
            class_valid          <= valid_next_s;
        end
    end

    // Compare pipeline and running maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r  <= 1'b0;
            rd_idx_r    <= '0;
            max_score_r <= '0;
            max_id_r    <= '0;
        end else begin
            rd_valid_r  <= outputs_read_en;
            rd_idx_r    <= CLASS_BITS'(outputs_read_address);
            max_score_r <= max_score_next_s;
            max_id_r    <= max_id_next_s;
        end
    end

    // Result registers: loaded once per run, stable while HOLD waits for ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_id    <= '0;
            class_score <= '0;
        end else if (load_result_s) begin
            class_id    <= max_id_next_s;
            class_score <= max_score_next_s;
        end else begin
            class_id    <= class_id;
            class_score <= class_score;
        end
    end

endmodule : argmax_classifier

// File: tb/tb_argmax_classifier.sv
// -----------------------------------------------------------------------------
// tb_argmax_classifier
// Self-checking bench for argmax_classifier: a behavioural outputs RAM with
// one-cycle read latency, and a reference argmax computed directly over the
// logit array (first index of the maximum value).
// -----------------------------------------------------------------------------
module tb_argmax_classifier;

    localparam int N = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        outputs_read_en;
    logic [3:0]  outputs_read_address;
    logic [31:0] outputs_read_data;
    logic        class_valid;
    logic        class_ready;
    logic [3:0]  class_id;
    logic [31:0] class_score;

    logic signed [31:0] logits [N];

    int n_vectors;
    int n_miscompares;

    argmax_classifier dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .busy                 (busy),
        .outputs_read_en      (outputs_read_en),
        .outputs_read_address (outputs_read_address),
        .outputs_read_data    (outputs_read_data),
        .class_valid          (class_valid),
        .class_ready          (class_ready),
        .class_id             (class_id),
        .class_score          (class_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs RAM model: registered read, data one cycle after read enable
    always @(posedge clk) begin
        if (outputs_read_en) begin
            outputs_read_data <= logits[outputs_read_address];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full classification: start, watch the read sequence, wait for the
    // result, optionally back-pressure and poke start while busy.
    task automatic run_case(input string name, input int hold_cycles, input bit poke_start);
        int          exp_id;
        logic signed [31:0] exp_max;
        int          c;
        int          reads;
        bit          addr_ok;
        bit          seen;
        bit          stable;
        bit          quiet;
        logic [3:0]  id_first;
        logic [31:0] score_first;

        exp_id  = 0;
        exp_max = logits[0];
        for (int i = 1; i < N; i++) begin
            if (logits[i] > exp_max) begin
                exp_max = logits[i];
                exp_id  = i;
            end
        end

        class_ready = (hold_cycles == 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({name, ".busy_after_start"}, {63'd0, busy}, 64'd1);

        c       = 1;
        reads   = 0;
        addr_ok = 1'b1;
        seen    = 1'b0;
        while (c <= 40) begin
            if (outputs_read_en) begin
                if (outputs_read_address != 4'(reads)) addr_ok = 1'b0;
                reads++;
            end
            if (class_valid) begin
                seen = 1'b1;
                break;
            end
            start = (poke_start && c == 5);
            @(negedge clk);
            c++;
        end
        start = 1'b0;

        check_eq({name, ".valid_seen"}, {63'd0, seen}, 64'd1);
        check_eq({name, ".latency"}, 64'(c), 64'd12);
        check_eq({name, ".read_count"}, 64'(reads), 64'(N));
        check_eq({name, ".read_order"}, {63'd0, addr_ok}, 64'd1);
        check_eq({name, ".read_en_in_hold"}, {63'd0, outputs_read_en}, 64'd0);
        check_eq({name, ".class_id"}, {60'd0, class_id}, 64'(exp_id));
        check_eq({name, ".class_score"}, {32'd0, class_score}, {32'd0, exp_max});

        id_first    = class_id;
        score_first = class_score;
        stable      = 1'b1;
        start       = poke_start;
        for (int j = 0; j < hold_cycles; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (class_id != id_first || class_score != score_first ||
                class_valid !== 1'b1 || busy !== 1'b1) stable = 1'b0;
        end
        if (hold_cycles > 0) begin
            check_eq({name, ".stable_under_backpressure"}, {63'd0, stable}, 64'd1);
        end

        class_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({name, ".valid_drop"}, {63'd0, class_valid}, 64'd0);
        check_eq({name, ".busy_drop"}, {63'd0, busy}, 64'd0);
        class_ready = 1'b0;

        quiet = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (outputs_read_en || class_valid || busy) quiet = 1'b0;
        end
        check_eq({name, ".idle_after"}, {63'd0, quiet}, 64'd1);
    endtask

    initial begin
        int  c;
        bit  reached;
        bit  quiet;

        n_vectors     = 0;
        n_miscompares = 0;
        start         = 1'b0;
        class_ready   = 1'b0;
        for (int i = 0; i < N; i++) logits[i] = 32'sd0;

        rst_n = 1'b0;
        #3;
        check_eq("reset.busy", {63'd0, busy}, 64'd0);
        check_eq("reset.read_en", {63'd0, outputs_read_en}, 64'd0);
        check_eq("reset.address", {60'd0, outputs_read_address}, 64'd0);
        check_eq("reset.valid", {63'd0, class_valid}, 64'd0);
        check_eq("reset.id", {60'd0, class_id}, 64'd0);
        check_eq("reset.score", {32'd0, class_score}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie between index 2 and 8 keeps the lower index
        logits[0] = 5;   logits[1] = -3;  logits[2] = 100; logits[3] = 7;
        logits[4] = 99;  logits[5] = 0;   logits[6] = -50; logits[7] = 12;
        logits[8] = 100; logits[9] = 1;
        run_case("tie", 0, 1'b0);

        // All negative, maximum at the last index
        for (int i = 0; i < 9; i++) logits[i] = -1000 + i * 110;
        logits[8] = -10;
        logits[9] = -7;
        run_case("negative", 0, 1'b0);

        // Signed extremes
        for (int i = 0; i < N; i++) logits[i] = 32'sd0;
        logits[4] = 32'sh7FFFFFFF;
        logits[0] = 32'sh80000000;
        run_case("extremes", 0, 1'b0);

        // Back-pressure for 20 cycles
        run_case("backpressure", 20, 1'b0);

        // start pulsed during READ and during HOLD is ignored
        for (int i = 0; i < N; i++) logits[i] = $urandom_range(0, 1000);
        run_case("poke_start", 3, 1'b1);

        // Reset in the middle of a read sequence
        for (int i = 0; i < N; i++) logits[i] = $urandom;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        reached = 1'b0;
        c       = 0;
        while (c < 30) begin
            if (outputs_read_en && outputs_read_address == 4'd5) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
            c++;
        end
        check_eq("abort.reached_addr5", {63'd0, reached}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort.read_en_async", {63'd0, outputs_read_en}, 64'd0);
        check_eq("abort.busy_async", {63'd0, busy}, 64'd0);
        check_eq("abort.address_async", {60'd0, outputs_read_address}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (class_valid || outputs_read_en || busy) quiet = 1'b0;
        end
        check_eq("abort.no_stale_result", {63'd0, quiet}, 64'd1);
        for (int i = 0; i < N; i++) logits[i] = $urandom;
        run_case("after_abort", 0, 1'b0);

        // Randomized runs; narrow value range in half of them to force ties
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t % 2 == 0) logits[i] = $signed($urandom_range(0, 6)) - 3;
                else            logits[i] = $urandom;
            end
            run_case($sformatf("rand%0d", t), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_argmax_classifier
